// File: rtl/cia_cnt_sp_pads_if.sv
// rtl/cia_cnt_sp_pads_if.sv - serial-side signal bundle between cia_serial and the CNT/SP pad front end
interface cia_cnt_sp_pads_if;
    logic phi2_up;
    logic phi2_dn;
    logic cnt_out;
    logic sp_out;
    logic cnt_up;
    logic cnt_level;
    logic sp_in;

    // master is the cia_serial / timing side, slave is the pad front end
    modport master (
        output phi2_up,
        output phi2_dn,
        output cnt_out,
        output sp_out,
        input  cnt_up,
        input  cnt_level,
        input  sp_in
    );

    modport slave (
        input  phi2_up,
        input  phi2_dn,
        input  cnt_out,
        input  sp_out,
        output cnt_up,
        output cnt_level,
        output sp_in
    );
endinterface

// File: rtl/cia_cnt_sp_pads.sv
// rtl/cia_cnt_sp_pads.sv - CIA CNT/SP pad synchronisers, CNT glitch filter and edge detect; CIA_CNT_GLITCH_FILTER_EN enables the filter
module cia_cnt_sp_pads #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic               clk,
    input  logic               res_n,
    input  logic               cnt_pad_i,
    input  logic               sp_pad_i,
    output logic               cnt_oe,
    output logic               sp_oe,
    cia_cnt_sp_pads_if.slave   ser
);

    logic [SYNC_STAGES-1:0] cnt_sync;
    logic [SYNC_STAGES-1:0] sp_sync;
    logic                   cnt_s;
    logic                   cnt_filt;
    logic                   cnt_level_q;
    logic                   cnt_up_q;

    // Idle-high reset so an undriven pad never looks like an edge after reset
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            cnt_sync <= '1;
            sp_sync  <= '1;
        end else begin
            cnt_sync <= {cnt_sync[SYNC_STAGES-2:0], cnt_pad_i};
            sp_sync  <= {sp_sync[SYNC_STAGES-2:0], sp_pad_i};
        end
    end

    assign cnt_s = cnt_sync[SYNC_STAGES-1];

`ifdef CIA_CNT_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILT_LEN + 1);

    logic [CW-1:0] filt_cnt;

    // Filtered level flips on the FILT_LEN-th consecutive differing sample
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            filt_cnt <= '0;
            cnt_filt <= 1'b1;
        end else if (cnt_s == cnt_filt) begin
            filt_cnt <= '0;
        end else if (filt_cnt >= CW'(FILT_LEN - 1)) begin
            filt_cnt <= '0;
            cnt_filt <= cnt_s;
        end else begin
            filt_cnt <= filt_cnt + CW'(1);
        end
    end
`else
    localparam int unused_filt_len = FILT_LEN;

    assign cnt_filt = cnt_s;
`endif

    // Sampled once per PHI2 cycle so cnt_up is stable across phi2_dn
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            cnt_level_q <= 1'b1;
            cnt_up_q    <= 1'b0;
        end else if (ser.phi2_up) begin
            cnt_level_q <= cnt_filt;
            cnt_up_q    <= cnt_filt & ~cnt_level_q;
        end
    end

    wire unused_phi2_dn = ser.phi2_dn;

    assign ser.cnt_level = cnt_level_q;
    assign ser.cnt_up    = cnt_up_q;
    assign ser.sp_in     = sp_sync[SYNC_STAGES-1];

    assign cnt_oe = ~ser.cnt_out;
    assign sp_oe  = ~ser.sp_out;

endmodule

// File: tb/tb_cia_cnt_sp_pads.sv
// tb/tb_cia_cnt_sp_pads.sv - directed self-checking bench for cia_cnt_sp_pads
module tb_cia_cnt_sp_pads;
    localparam int S = 2;
    localparam int F = 4;
    localparam int P = 16;
`ifdef CIA_CNT_GLITCH_FILTER_EN
    localparam int LAT = S + F;
    localparam int PL  = F;
`else
    localparam int LAT = S;
    localparam int PL  = 1;
`endif

    logic clk = 1'b0;
    logic res_n;
    logic cnt_pad_i;
    logic sp_pad_i;
    logic cnt_oe;
    logic sp_oe;

    cia_cnt_sp_pads_if ser_if ();

    cia_cnt_sp_pads #(.SYNC_STAGES(S), .FILT_LEN(F)) dut (
        .clk       (clk),
        .res_n     (res_n),
        .cnt_pad_i (cnt_pad_i),
        .sp_pad_i  (sp_pad_i),
        .cnt_oe    (cnt_oe),
        .sp_oe     (sp_oe),
        .ser       (ser_if)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int phase  = 0;
    int sq_cnt = 0;
    bit sq_en  = 1'b0;
    bit seen_up = 1'b0;
    bit prev_up = 1'b0;
    int up_cnt = 0;
    int dbl_cnt = 0;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clk: update PHI2 strobes, square wave and monitors 2 ns after the edge
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            phase = (phase + 1) % P;
            ser_if.phi2_up = (phase == 0);
            ser_if.phi2_dn = (phase == P / 2);
            if (sq_en) begin
                cnt_pad_i = (sq_cnt < 6);
                sq_cnt = (sq_cnt + 1) % 12;
            end
            if (ser_if.cnt_up === 1'b1) seen_up = 1'b1;
            if (phase == 1) begin
                if (ser_if.cnt_up === 1'b1) begin
                    up_cnt++;
                    if (prev_up) dbl_cnt++;
                end
                prev_up = (ser_if.cnt_up === 1'b1);
            end
        end
    endtask

    task automatic go_phase(input int p);
        while (phase != p) step(1);
    endtask

    initial begin
        res_n = 1'b0;
        cnt_pad_i = 1'b1;
        sp_pad_i = 1'b1;
        ser_if.phi2_up = 1'b0;
        ser_if.phi2_dn = 1'b0;
        ser_if.cnt_out = 1'b0;
        ser_if.sp_out = 1'b1;
        step(3);
        #1;
        chk("oe_in_reset", cnt_oe, 1'b1);
        chk("up_in_reset", ser_if.cnt_up, 1'b0);
        ser_if.cnt_out = 1'b1;
        res_n = 1'b1;
        step(5);
        chk("rst_cnt_up", ser_if.cnt_up, 1'b0);
        chk("rst_cnt_level", ser_if.cnt_level, 1'b1);
        chk("rst_sp_in", ser_if.sp_in, 1'b1);
        chk("rst_cnt_oe", cnt_oe, 1'b0);
        chk("rst_sp_oe", sp_oe, 1'b0);

        // Fall, then a rise timed so it is seen at the earliest possible sample
        go_phase(1);
        cnt_pad_i = 1'b0;
        step(P);
        chk("fall_level", ser_if.cnt_level, 1'b0);
        chk("fall_no_up", ser_if.cnt_up, 1'b0);
        go_phase(P - LAT);
        cnt_pad_i = 1'b1;
        step(LAT);
        chk("rise_before_lat", ser_if.cnt_up, 1'b0);
        step(1);
        chk("rise_onset", ser_if.cnt_up, 1'b1);
        chk("rise_level", ser_if.cnt_level, 1'b1);
        step(P - 1);
        chk("rise_held", ser_if.cnt_up, 1'b1);
        step(1);
        chk("rise_one_cycle", ser_if.cnt_up, 1'b0);

        // Rise one clk too late for that sample lands in the next PHI2 cycle
        cnt_pad_i = 1'b0;
        step(2 * P);
        go_phase(P - LAT + 1);
        cnt_pad_i = 1'b1;
        step(LAT);
        chk("late_rise_missed", ser_if.cnt_up, 1'b0);
        step(P);
        chk("late_rise_next", ser_if.cnt_up, 1'b1);

`ifdef CIA_CNT_GLITCH_FILTER_EN
        // Pulse one clk shorter than the filter length is rejected
        step(2 * P);
        go_phase(P - LAT);
        seen_up = 1'b0;
        cnt_pad_i = 1'b0;
        step(F - 1);
        cnt_pad_i = 1'b1;
        step(LAT + 2 - F);
        chk("glitch_level", ser_if.cnt_level, 1'b1);
        step(2 * P);
        chk("glitch_no_up", seen_up, 1'b0);
`endif

        // Shortest accepted pulse, placed so its filtered low hits a sample
        step(2 * P);
        go_phase(P - LAT);
        cnt_pad_i = 1'b0;
        step(PL);
        cnt_pad_i = 1'b1;
        step(LAT + 1 - PL);
        chk("pulse_level_low", ser_if.cnt_level, 1'b0);
        chk("pulse_up_low", ser_if.cnt_up, 1'b0);
        step(P);
        chk("pulse_level_high", ser_if.cnt_level, 1'b1);
        chk("pulse_up", ser_if.cnt_up, 1'b1);

        // 12-clk square wave against a 16-clk PHI2: one rise every third sample
        sq_cnt = 0;
        sq_en = 1'b1;
        step(3 * P);
        go_phase(1);
        up_cnt = 0;
        dbl_cnt = 0;
        prev_up = 1'b0;
        step(12 * P);
        sq_en = 1'b0;
        cnt_pad_i = 1'b1;
        chk_int("square_up_count", up_cnt, 4);
        chk_int("square_double", dbl_cnt, 0);

        // SP latency and combinational open-drain enables
        step(2 * P);
        sp_pad_i = 1'b0;
        step(S - 1);
        chk("sp_fall_early", ser_if.sp_in, 1'b1);
        step(1);
        chk("sp_fall", ser_if.sp_in, 1'b0);
        sp_pad_i = 1'b1;
        step(S - 1);
        chk("sp_rise_early", ser_if.sp_in, 1'b0);
        step(1);
        chk("sp_rise", ser_if.sp_in, 1'b1);
        ser_if.cnt_out = 1'b0;
        #1;
        chk("cnt_oe_on", cnt_oe, 1'b1);
        ser_if.sp_out = 1'b0;
        #1;
        chk("sp_oe_on", sp_oe, 1'b1);
        ser_if.cnt_out = 1'b1;
        ser_if.sp_out = 1'b1;
        #1;
        chk("cnt_oe_off", cnt_oe, 1'b0);
        chk("sp_oe_off", sp_oe, 1'b0);

        // Asynchronous reset while cnt_up is high, release with CNT high
        cnt_pad_i = 1'b0;
        step(2 * P);
        go_phase(1);
        cnt_pad_i = 1'b1;
        step(P);
        chk("pre_reset_up", ser_if.cnt_up, 1'b1);
        #1;
        res_n = 1'b0;
        #1;
        chk("reset_async_up", ser_if.cnt_up, 1'b0);
        chk("reset_async_level", ser_if.cnt_level, 1'b1);
        step(3);
        res_n = 1'b1;
        seen_up = 1'b0;
        step(3 * P);
        chk("release_no_up", seen_up, 1'b0);
        chk("release_level", ser_if.cnt_level, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
